// File: rtl/load_store_unit.sv
// Memory-access stage: drives a word-wide request/ready memory port for loads and stores,
// builds byte enables and lane-replicated store data, and extends load data. Optional macro: MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter logic [6:0]  LTYPE   = 7'b0000011,
    parameter logic [6:0]  STYPE   = 7'b0100011,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam int             TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]  T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]    state;
    logic [TW-1:0] tcnt;
    logic          load_q;
    logic          uns_q;
    logic [1:0]    size_q;
    logic [1:0]    off_q;

    logic          legal;
    logic          accept;
    logic [1:0]    off;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   ext;

    // Request decode; the lane offset is forced to natural alignment for the access size.
    always_comb begin
        legal = 1'b0;
        if (opcode == LTYPE) begin
            case (func3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end else if (opcode == STYPE) begin
            case (func3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                default:                legal = 1'b0;
            endcase
        end

        off   = addr[1:0];
        be    = 4'b1111;
        wdata = store_data;
        case (func3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                off   = {addr[1], 1'b0};
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: off = 2'b00;
        endcase
        if (opcode != STYPE) wdata = '0;
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                        ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign accept     = legal && !misaligned;
`else
    assign accept = legal;
`endif

    always_comb begin
        case (off_q)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ext = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'b01:   ext = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: ext = mem_rdata;
        endcase
    end

    // NOTE: mem_req/busy/done decode straight from the async-reset state register,
    // so reset drops the request without waiting for a clock edge.
    assign mem_req = (state == S_ACCESS);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            load_q    <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            load_data <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err   <= !accept;
                        state <= accept ? S_ACCESS : S_DONE;
                        if (accept) begin
                            tcnt      <= '0;
                            load_q    <= (opcode == LTYPE);
                            uns_q     <= func3[2];
                            size_q    <= func3[1:0];
                            off_q     <= off;
                            mem_we    <= (opcode == STYPE);
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be;
                            mem_wdata <= wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_ready) begin
                        state <= S_DONE;
                        err   <= 1'b0;
                        if (load_q) load_data <= ext;
                    end else if ((TIMEOUT != 0) && (tcnt == T_LAST)) begin
                        state <= S_DONE;
                        err   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table driven through a scoreboard queue,
// plus hand sequences for start-in-DONE and reset during an access.
module tb_load_store_unit;

    localparam logic [6:0] LT = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam int         TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        err;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.LTYPE(LT), .STYPE(ST), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .func3(func3),
        .addr(addr), .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .load_data(load_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          ready_cyc;   // 0 = never ready
        int          poke_cyc;    // cycle of a stray start during ACCESS, 0 = none
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic        chk_ld;
        logic [31:0] exp_ld;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [6:0] op, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                                input int rc, input int pc, input logic req, input logic [31:0] ea,
                                input logic [3:0] eb, input logic [31:0] ew, input logic we,
                                input logic cl, input logic [31:0] el, input logic ee);
        vec_t v;
        v.name = n; v.opcode = op; v.func3 = f3; v.addr = a; v.sd = sd; v.rdata = rd;
        v.ready_cyc = rc; v.poke_cyc = pc; v.exp_req = req; v.exp_addr = ea; v.exp_be = eb;
        v.exp_wdata = ew; v.exp_we = we; v.chk_ld = cl; v.exp_ld = el; v.exp_err = ee;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int   cyc;
        int   req_cnt;
        int   exp_done;
        bit   seen;
        vec_t e;
        exp_done = !v.exp_req ? 1 : (v.ready_cyc == 0 ? TO + 1 : v.ready_cyc + 1);
        @(negedge clk);
        opcode = v.opcode; func3 = v.func3; addr = v.addr; store_data = v.sd; start = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; req_cnt = 0; seen = 0;
        check({v.name, ".req"}, 32'(mem_req), 32'(v.exp_req));
        if (v.exp_req) begin
            check({v.name, ".addr"}, mem_addr, v.exp_addr);
            check({v.name, ".be"}, 32'(mem_be), 32'(v.exp_be));
            check({v.name, ".wdata"}, mem_wdata, v.exp_wdata);
            check({v.name, ".we"}, 32'(mem_we), 32'(v.exp_we));
        end
        while (!seen && cyc < 60) begin
            if (done) begin
                seen = 1;
                e = exp_q.pop_front();
                check({e.name, ".done_cyc"}, 32'(cyc), 32'(exp_done));
                check({e.name, ".req_cycles"}, 32'(req_cnt), 32'(e.exp_req ? exp_done - 1 : 0));
                check({e.name, ".err"}, 32'(err), 32'(e.exp_err));
                check({e.name, ".req_low"}, 32'(mem_req), 32'd0);
                if (e.chk_ld) check({e.name, ".load_data"}, load_data, e.exp_ld);
            end else begin
                if (mem_req) req_cnt++;
                mem_ready = v.exp_req && (cyc == v.ready_cyc);
                mem_rdata = v.rdata;
                if (cyc == v.poke_cyc) begin
                    start = 1'b1; opcode = ST; func3 = 3'b000; addr = v.addr ^ 32'hFF0;
                end
                @(negedge clk);
                mem_ready = 1'b0; start = 1'b0;
                cyc++;
            end
        end
        if (!seen) check({v.name, ".done_timeout"}, 32'd0, 32'd1);
        if (v.exp_req) begin
            check({v.name, ".addr_held"}, mem_addr, v.exp_addr);
            check({v.name, ".we_held"}, 32'(mem_we), 32'(v.exp_we));
        end
        @(negedge clk);
        check({v.name, ".idle_after"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        bit dseen;
        rst_n = 1'b0; start = 1'b0; opcode = '0; func3 = '0; addr = '0;
        store_data = '0; mem_ready = 1'b0; mem_rdata = '0;

        vecs.push_back(mk("sw",      ST, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 2, 0, 1, 32'h104, 4'b1111, 32'hDEADBEEF, 1, 0, 32'h0, 0));
        vecs.push_back(mk("sb3",     ST, 3'b000, 32'h203, 32'h000000A5, 32'h0, 1, 0, 1, 32'h200, 4'b1000, 32'hA5A5A5A5, 1, 0, 32'h0, 0));
        vecs.push_back(mk("sb1",     ST, 3'b000, 32'h201, 32'h1234567C, 32'h0, 1, 0, 1, 32'h200, 4'b0010, 32'h7C7C7C7C, 1, 0, 32'h0, 0));
        vecs.push_back(mk("lb",      LT, 3'b000, 32'h302, 32'h0, 32'h12F03456, 1, 0, 1, 32'h300, 4'b0100, 32'h0, 0, 1, 32'hFFFFFFF0, 0));
        vecs.push_back(mk("lbu",     LT, 3'b100, 32'h302, 32'h0, 32'h12F03456, 3, 0, 1, 32'h300, 4'b0100, 32'h0, 0, 1, 32'h000000F0, 0));
        vecs.push_back(mk("lhu",     LT, 3'b101, 32'h302, 32'h0, 32'h12F03456, 1, 0, 1, 32'h300, 4'b1100, 32'h0, 0, 1, 32'h000012F0, 0));
        vecs.push_back(mk("lh",      LT, 3'b001, 32'h300, 32'h0, 32'h12348001, 2, 0, 1, 32'h300, 4'b0011, 32'h0, 0, 1, 32'hFFFF8001, 0));
        vecs.push_back(mk("sh",      ST, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 1, 0, 1, 32'h100, 4'b1100, 32'hBEEFBEEF, 1, 0, 32'h0, 0));
        vecs.push_back(mk("lw",      LT, 3'b010, 32'h040, 32'h0, 32'hCAFEF00D, 1, 0, 1, 32'h040, 4'b1111, 32'h0, 0, 1, 32'hCAFEF00D, 0));
        vecs.push_back(mk("lw_to",   LT, 3'b010, 32'h080, 32'h0, 32'h5A5A5A5A, 0, 0, 1, 32'h080, 4'b1111, 32'h0, 0, 1, 32'hCAFEF00D, 1));
        vecs.push_back(mk("ill_op",  7'b0110011, 3'b000, 32'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'hCAFEF00D, 1));
        vecs.push_back(mk("ill_ld",  LT, 3'b011, 32'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, 1));
        vecs.push_back(mk("ill_st",  ST, 3'b100, 32'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, 1));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk("lh_mis",  LT, 3'b001, 32'h101, 32'h0, 32'h00008765, 1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'hCAFEF00D, 1));
        vecs.push_back(mk("lw_mis",  LT, 3'b010, 32'h106, 32'h0, 32'h89ABCDEF, 2, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'hCAFEF00D, 1));
`else
        vecs.push_back(mk("lh_mis",  LT, 3'b001, 32'h101, 32'h0, 32'h00008765, 1, 0, 1, 32'h100, 4'b0011, 32'h0, 0, 1, 32'hFFFF8765, 0));
        vecs.push_back(mk("lw_mis",  LT, 3'b010, 32'h106, 32'h0, 32'h89ABCDEF, 2, 0, 1, 32'h104, 4'b1111, 32'h0, 0, 1, 32'h89ABCDEF, 0));
`endif
        vecs.push_back(mk("lw_poke", LT, 3'b010, 32'h010, 32'h0, 32'h11223344, 4, 2, 1, 32'h010, 4'b1111, 32'h0, 0, 1, 32'h11223344, 0));

        repeat (2) @(negedge clk);
        check("rst.ctrl", 32'({mem_req, mem_we, busy, done, err}), 32'd0);
        check("rst.addr", mem_addr, 32'h0);
        check("rst.be_wdata", 32'(mem_be) | mem_wdata, 32'h0);
        check("rst.load_data", load_data, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
        check("sb.empty", 32'(exp_q.size()), 32'd0);

        // start during the DONE cycle is ignored; held one more cycle it is accepted
        @(negedge clk);
        opcode = 7'b0110011; func3 = 3'b000; start = 1'b1;
        @(negedge clk);
        check("dn.done", 32'(done), 32'd1);
        opcode = LT; func3 = 3'b010; addr = 32'h500;
        @(negedge clk);
        check("dn.start_ignored", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("dn.accepted_req", 32'(mem_req), 32'd1);
        check("dn.accepted_addr", mem_addr, 32'h500);
        mem_ready = 1'b1; mem_rdata = 32'h55;
        @(negedge clk);
        mem_ready = 1'b0;
        check("dn.done2", 32'(done), 32'd1);
        check("dn.load_data", load_data, 32'h55);

        // reset in the middle of ACCESS
        @(negedge clk);
        opcode = LT; func3 = 3'b010; addr = 32'h600; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mr.req_before", 32'(mem_req), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mr.req_drop", 32'(mem_req), 32'd0);
        check("mr.busy", 32'(busy), 32'd0);
        check("mr.load_data", load_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dseen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) dseen = 1;
        end
        check("mr.no_done", 32'(dseen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle memory-access stage directly downstream of the ALU. On a load or store, the ALU result is the effective address; this block drives a word-wide memory port through a request/ready handshake. It generates byte-lane enables and replicated store data. It also extracts and sign- or zero-extends load data, then hands the result to writeback with a one-cycle done pulse.

Parameters:
LTYPE, 7'b0000011, load opcode
STYPE, 7'b0100011, store opcode
TIMEOUT, 16, maximum ACCESS cycles without mem_ready before abort; 0 disables the timeout

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin access; sampled only in IDLE
opcode  input  7  instruction opcode, captured on start
func3  input  3  access size/sign, captured on start
addr  input  32  effective address (ALU result), captured on start
store_data  input  32  rs2 value, captured on start
mem_req  output  1  memory request, held until accepted
mem_we  output  1  1 = write
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_be  output  4  byte-lane enables
mem_wdata  output  32  lane-replicated store data
mem_ready  input  1  memory accepted the request; read data valid in the same cycle
mem_rdata  input  32  read word
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
load_data  output  32  extended load result, held until the next done
err  output  1  valid with done: illegal op, timeout or misalignment

Behaviour:
- Reset: state=IDLE. All outputs are 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy, done, load_data, err. The timeout counter is 0.
- States: IDLE, ACCESS, DONE.
- IDLE, start=1, legal op: capture the inputs and go to ACCESS. Legal ops are:
  - loads: func3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
  - stores: func3 000 sb, 001 sh, 010 sw
- IDLE, start=1, illegal opcode or func3: go to DONE with err=1. No memory request is issued.
- ACCESS:
  - mem_req=1, and mem_we/mem_addr/mem_be/mem_wdata are held stable.
  - When mem_ready=1, go to DONE; for loads, the extended mem_rdata is registered into load_data.
  - Timeout: the counter increments each ACCESS cycle without mem_ready. When it reaches TIMEOUT, go to DONE with err=1, deassert mem_req and leave load_data unchanged.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in IDLE only.
- Latency: start at cycle 0 gives mem_req from cycle 1. mem_ready in cycle k gives done in cycle k+1. Minimum latency is 2 cycles (mem_ready in cycle 1).
- start while busy is ignored. start in the same cycle that DONE returns to IDLE is also ignored; it is accepted from the following cycle.
- Byte enables:
  - byte: mem_be = 4'b0001 << addr[1:0]
  - half: mem_be = addr[1] ? 4'b1100 : 4'b0011
  - word: mem_be = 4'b1111
- Store data: byte {4{sd[7:0]}}, half {2{sd[15:0]}}, word sd. For loads, mem_be is set the same way and mem_wdata=0.
- Load extraction: select the byte at lane addr[1:0] or the half at lane addr[1]. lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- Reset mid-ACCESS: return to IDLE immediately and drop mem_req asynchronously. No done pulse is produced.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE->DONE with err=1. No mem_req is issued.
- Undefined: the offending low address bits are treated as 0 (natural alignment forced) and the access proceeds normally; err is only asserted for an illegal op or a timeout.

Test Plan:
- sw, addr=0x104, sd=0xDEADBEEF, mem_ready in cycle 2 -> mem_addr=0x104, be=1111, wdata=0xDEADBEEF, we=1; done in cycle 3, err=0.
- sb, addr=0x203, sd=0x000000A5 -> mem_addr=0x200, be=1000, wdata=0xA5A5A5A5.
- lb, addr=0x302, rdata=0x12F0_3456 -> load_data=0xFFFFFFF0. lbu at the same address -> 0x000000F0. lhu, addr=0x302 -> 0x000012F0.
- lw with mem_ready held 0 and TIMEOUT=16 -> mem_req high for 16 cycles, then done=1, err=1, mem_req=0.
- opcode=0110011 with start, and a start pulse during ACCESS -> illegal: done=1, err=1, no mem_req. The start during ACCESS does not restart or extend the access.
- lh, addr=0x101:
  - with MISALIGN_TRAP_EN: done=1, err=1, no mem_req.
  - without it: mem_be=0011, err=0.
- rst_n low in the middle of ACCESS -> mem_req=0 immediately, state IDLE, no done pulse.
